// File: rtl/led_phy_tx.sv
//----------------------------------------------------------------------------
// led_phy_tx
//
// Reads one frame of pixels from the LED frame FIFO and drives them onto a
// WS2812-style single-wire NRZ line.
//
// Frame sequence:
//   1. send_start begins a frame.
//   2. PIX_NUM 12-bit {B,G,R} nibble entries are popped from the FIFO.
//   3. Each entry is expanded to a 24-bit word in G,R,B order.
//   4. The word is sent MSB first.
//   5. The frame ends with a TRST-cycle low latch period and a done pulse.
//
// Timing at pixel boundaries: the FIFO pop (RD) and data capture (LOAD)
// cycles come out of the low time of the previous pixel's last bit. Every
// bit period is therefore exactly TxH+TxL.
//
// Optional feature (compile-time macro LED_TX_GAMMA_EN):
//   undefined : X8 = {X4, X4}        (nibble replicate)
//   defined   : X8 = X4*X4 + X4      (square-law gamma)
//
// Ports:
//   clk         in   clock
//   rstn        in   asynchronous active-low reset
//   send_start  in   one-cycle frame start request (ignored unless idle)
//   fifo_dout   in   [3:0]=R [7:4]=G [11:8]=B, valid the cycle after rd_en
//   fifo_empty  in   FIFO empty flag
//   rd_en       out  FIFO pop, one cycle per pixel
//   led_dout    out  registered serial LED line
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse on the last latch cycle
//   uflow       out  one-cycle pulse when the FIFO is empty at a pop point
//----------------------------------------------------------------------------
module led_phy_tx #(
    parameter int PIX_NUM = 47,
    parameter int T0H     = 20,
    parameter int T0L     = 42,
    parameter int T1H     = 40,
    parameter int T1L     = 22,
    parameter int TRST    = 3000,
    parameter int CW      = 12
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        send_start,
    input  logic [11:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        rd_en,
    output logic        led_dout,
    output logic        busy,
    output logic        done,
    output logic        uflow
);

    localparam int PW = $clog2(PIX_NUM + 1);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LOAD,
        HIGH,
        LOW,
        LATCH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt;
    logic [23:0]    shift_reg;
    logic [4:0]     bit_idx;
    logic [PW-1:0]  pix_cnt;

    logic           cur_bit;
    logic           last_bit;
    logic           more_pix;
    logic           phase_end;
    logic [CW-1:0]  hi_len;
    logic [CW-1:0]  lo_len;

    // Nibble to 8-bit channel expansion.
    function automatic logic [7:0] expand(input logic [3:0] x);
        logic [7:0] x8;
        x8 = {4'h0, x};
`ifdef LED_TX_GAMMA_EN
        return x8 * x8 + x8;
`else
        return {x, x};
`endif
    endfunction

    // Phase lengths for the bit currently at the head of the shift register.
    // The last bit of a pixel that is followed by another pixel loses two low
    // cycles; RD and LOAD fill them so the bit period stays constant.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a signal unassigned would infer a latch.
        cur_bit   = shift_reg[23];
        last_bit  = (bit_idx == 5'd0);
        more_pix  = (pix_cnt < PW'(PIX_NUM));
        hi_len    = cur_bit ? CW'(T1H) : CW'(T0H);
        lo_len    = cur_bit ? CW'(T1L) : CW'(T0L);
        if (last_bit && more_pix) begin
            lo_len = cur_bit ? CW'(T1L - 2) : CW'(T0L - 2);
        end
        phase_end = 1'b0;
        case (state_q)
            HIGH:    phase_end = (cnt == hi_len - CW'(1));
            LOW:     phase_end = (cnt == lo_len - CW'(1));
            LATCH:   phase_end = (cnt == CW'(TRST - 1));
            default: phase_end = 1'b0;
        endcase
    end

    // Next state and strobe outputs.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        uflow   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_start) begin
                    state_d = RD;
                end
            end
            RD: begin
                if (fifo_empty) begin
                    uflow   = 1'b1;
                    state_d = LATCH;
                end else begin
                    rd_en   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = HIGH;
            end
            HIGH: begin
                if (phase_end) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                if (phase_end) begin
                    if (!last_bit) begin
                        state_d = HIGH;
                    end else if (more_pix) begin
                        state_d = RD;
                    end else begin
                        state_d = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt       <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
            pix_cnt   <= '0;
            led_dout  <= 1'b0;
        end else begin
            state_q <= state_d;

            // The phase timer restarts on every state change.
            if (state_d != state_q) begin
                cnt <= '0;
            end else if (state_q == HIGH || state_q == LOW || state_q == LATCH) begin
                cnt <= cnt + CW'(1);
            end

            // Registered line: high exactly while the FSM is in HIGH.
            led_dout <= (state_d == HIGH);

            case (state_q)
                LOAD: begin
                    shift_reg <= {expand(fifo_dout[7:4]),
                                  expand(fifo_dout[3:0]),
                                  expand(fifo_dout[11:8])};
                    bit_idx   <= 5'd23;
                    pix_cnt   <= pix_cnt + PW'(1);
                end
                LOW: begin
                    if (phase_end && !last_bit) begin
                        shift_reg <= {shift_reg[22:0], 1'b0};
                        bit_idx   <= bit_idx - 5'd1;
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        pix_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_phy_tx.sv
//----------------------------------------------------------------------------
// tb_led_phy_tx
//
// Self-checking bench for led_phy_tx.
//
// Shortened timing parameters keep each frame to a few hundred cycles. The
// expected line waveform for a frame is built cycle by cycle from the pixel
// list using the protocol rules:
//   - two setup cycles;
//   - contiguous TxH/TxL bit periods;
//   - the latch period.
// The observed line is then compared against it.
//----------------------------------------------------------------------------
module tb_led_phy_tx;

    localparam int PIX  = 4;
    localparam int T0H  = 3;
    localparam int T0L  = 6;
    localparam int T1H  = 6;
    localparam int T1L  = 3;
    localparam int TRST = 25;

    logic        clk = 1'b0;
    logic        rstn;
    logic        send_start;
    logic [11:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        rd_en;
    logic        led_dout;
    logic        busy;
    logic        done;
    logic        uflow;

    int total = 0;
    int bad   = 0;

    logic [11:0] fifo_q[$];
    logic [11:0] frame_pix[$];
    logic        rd_seen = 1'b0;

    led_phy_tx #(
        .PIX_NUM (PIX),
        .T0H     (T0H),
        .T0L     (T0L),
        .T1H     (T1H),
        .T1L     (T1L),
        .TRST    (TRST),
        .CW      (12)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .send_start (send_start),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en),
        .led_dout   (led_dout),
        .busy       (busy),
        .done       (done),
        .uflow      (uflow)
    );

    always #5 clk = ~clk;

    // FIFO model: the pop request is taken mid-cycle; data is valid the
    // cycle after the pop.
    always @(negedge clk) rd_seen = rd_en;

    always @(posedge clk) begin
        if (rd_seen && fifo_q.size() > 0) begin
            fifo_dout <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp4(input logic [3:0] x);
        int v;
`ifdef LED_TX_GAMMA_EN
        v = int'(x) * int'(x) + int'(x);
`else
        v = int'(x) * 17;
`endif
        return v[7:0];
    endfunction

    function automatic logic [23:0] grb_word(input logic [11:0] p);
        return {exp4(p[7:4]), exp4(p[3:0]), exp4(p[11:8])};
    endfunction

    // Push frame_pix into the FIFO, pulse send_start and compare the whole
    // frame. With restarts set, send_start is re-pulsed mid-frame and during
    // the latch period.
    task automatic run_frame(input string tag, input bit restarts);
        logic        exp_led[$];
        logic [23:0] w;
        int sent, uf_idx, len;
        int led_err, busy_err, rd_cnt, done_cnt, done_idx, uf_cnt, uf_seen;
        int ra, rb;

        fifo_q.delete();
        sent   = (frame_pix.size() < PIX) ? frame_pix.size() : PIX;
        uf_idx = -1;

        if (sent > 0) begin
            exp_led.push_back(1'b0);
            exp_led.push_back(1'b0);
            for (int p = 0; p < sent; p++) begin
                w = grb_word(frame_pix[p]);
                for (int b = 23; b >= 0; b--) begin
                    for (int c = 0; c < (w[b] ? T1H : T0H); c++) exp_led.push_back(1'b1);
                    for (int c = 0; c < (w[b] ? T1L : T0L); c++) exp_led.push_back(1'b0);
                end
            end
        end
        if (sent < PIX) begin
            if (sent > 0) begin
                // No LOAD follows the failed pop: the RD cycle is the last
                // line-low cycle before the latch.
                void'(exp_led.pop_back());
                uf_idx = exp_led.size() - 1;
            end else begin
                exp_led.push_back(1'b0);
                uf_idx = 0;
            end
        end
        for (int c = 0; c < TRST; c++) exp_led.push_back(1'b0);
        len = exp_led.size();
        ra  = restarts ? 50 : -1;
        rb  = restarts ? len - 3 : -1;

        foreach (frame_pix[i]) fifo_q.push_back(frame_pix[i]);
        repeat (2) @(negedge clk);

        send_start = 1'b1;
        @(negedge clk);
        send_start = 1'b0;

        led_err  = 0;
        busy_err = 0;
        rd_cnt   = 0;
        done_cnt = 0;
        done_idx = -1;
        uf_cnt   = 0;
        uf_seen  = -1;
        for (int i = 0; i < len + 10; i++) begin
            if (led_dout !== ((i < len) ? exp_led[i] : 1'b0)) led_err++;
            if (busy !== (i < len)) busy_err++;
            if (rd_en === 1'b1) rd_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_idx = i;
            end
            if (uflow === 1'b1) begin
                uf_cnt++;
                uf_seen = i;
            end
            send_start = (i == ra || i == rb);
            @(negedge clk);
        end
        send_start = 1'b0;

        check({tag, "_led_err_cycles"}, led_err, 0);
        check({tag, "_busy_err_cycles"}, busy_err, 0);
        check({tag, "_rd_en_count"}, rd_cnt, sent);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_idx, len - 1);
        check({tag, "_uflow_count"}, uf_cnt, (sent < PIX) ? 1 : 0);
        if (sent < PIX) check({tag, "_uflow_cycle"}, uf_seen, uf_idx);
        check({tag, "_fifo_left"}, fifo_q.size(), frame_pix.size() - sent);
    endtask

    task automatic fill_random(input int n);
        frame_pix.delete();
        for (int i = 0; i < n; i++) frame_pix.push_back(12'($urandom));
    endtask

    initial begin
        int done_cnt;

        rstn       = 1'b0;
        send_start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_led", led_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_done", done, 0);
        check("rst_uflow", uflow, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Known pattern 0x00AAFF first, then random pixels.
        fill_random(PIX);
        frame_pix[0] = 12'hF0A;
        run_frame("known", 1'b0);

        for (int k = 0; k < 3; k++) begin
            fill_random(PIX);
            run_frame($sformatf("rand%0d", k), 1'b0);
        end

        // Underflow with a partly filled FIFO, and with an empty FIFO.
        fill_random(3);
        run_frame("uflow3", 1'b0);
        fill_random(0);
        run_frame("uflow0", 1'b0);

        // Extra entries would be consumed if a re-pulse were honoured.
        fill_random(PIX + 2);
        run_frame("restart", 1'b1);

        // Reset in the high phase of bit 10 of the first (all-ones) pixel.
        fifo_q.delete();
        fill_random(PIX);
        frame_pix[0] = 12'hFFF;
        foreach (frame_pix[i]) fifo_q.push_back(frame_pix[i]);
        repeat (2) @(negedge clk);
        send_start = 1'b1;
        @(negedge clk);
        send_start = 1'b0;
        repeat (2 + 10 * (T1H + T1L) + 1) @(negedge clk);
        check("pre_rst_led", led_dout, 1);
        rstn = 1'b0;
        #1;
        check("midrst_led", led_dout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rd_en", rd_en, 0);
        repeat (2) @(negedge clk);
        rstn     = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 3 * TRST; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("post_rst_quiet", done_cnt, 0);

        fill_random(PIX);
        run_frame("after_rst", 1'b0);

        // Gamma sample entry; the model applies the build's expansion.
        fill_random(PIX);
        frame_pix[0] = 12'h18F;
        run_frame("gamma", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_phy_tx.md
Name: led_phy_tx

Overview:
- FIFO reader and serializer on the far side of the LED frame FIFO.
- Each frame is started by the one-cycle send_start pulse from the FIFO filler.
- Pops PIX_NUM 12-bit {B,G,R} nibble entries, expands each to a 24-bit GRB word, and drives a WS2812-style single-wire NRZ line.
- Closes every frame with a latch (reset-low) period, then pulses done.

Parameters:
- PIX_NUM, 47, pixels (FIFO entries) per frame.
- T0H, 20, clk cycles high for a 0 bit.
- T0L, 42, clk cycles low for a 0 bit (must be >= 3).
- T1H, 40, clk cycles high for a 1 bit.
- T1L, 22, clk cycles low for a 1 bit (must be >= 3).
- TRST, 3000, clk cycles of latch low after the last bit.
- CW, 12, timing counter width (must hold max(TRST, T*H, T*L)).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- send_start  in  1  one-cycle frame start request.
- fifo_dout  in  12  FIFO read data: [3:0]=R, [7:4]=G, [11:8]=B; valid the cycle after rd_en.
- fifo_empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO pop, one cycle per pixel.
- led_dout  out  1  serial LED line.
- busy  out  1  high from the cycle after send_start is accepted until the done cycle (inclusive).
- done  out  1  one-cycle pulse at frame end.
- uflow  out  1  one-cycle pulse when the FIFO is empty at a pop point.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States:
  - IDLE: wait for send_start. send_start -> RD. send_start in any other state is ignored.
  - RD: if fifo_empty=0, rd_en=1 for this cycle and go to LOAD. If fifo_empty=1, rd_en=0, uflow=1 and go to LATCH (frame aborted).
  - LOAD: capture fifo_dout, expand to shift_reg[23:0] = {G8,R8,B8}, bit_idx=23, pix_cnt+1, go to HIGH.
  - HIGH: led_dout=1 for T1H cycles if the current bit is 1, else T0H cycles; then go to LOW.
  - LOW: led_dout=0 for T1L or T0L cycles.
    - If bit_idx>0: decrement bit_idx, go to HIGH.
    - If bit_idx=0 and pix_cnt<PIX_NUM: the LOW phase lasts TxL-2 cycles, then RD. RD and LOAD keep led_dout=0, so the bit period stays exactly TxH+TxL with no inter-pixel gap.
    - If bit_idx=0 and pix_cnt=PIX_NUM: go to LATCH after the full TxL.
  - LATCH: led_dout=0 for TRST cycles. On the last cycle done=1, then go to IDLE with pix_cnt cleared.
- Bit order: MSB first; G8, then R8, then B8.
- Expansion (default): X8 = {X4, X4}, e.g. 4'hA -> 8'hAA, 4'hF -> 8'hFF.
- led_dout is registered: no combinational path from inputs.
- Underflow: frame aborts; the line holds low for the full TRST; done still pulses; the remaining entries stay in the FIFO.
- Reset mid-frame: immediate return to IDLE, led_dout=0, no done pulse.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro LED_TX_GAMMA_EN.
- Defined: expansion uses X8 = X4*X4 + X4 (unsigned 8-bit; 0->0, 1->2, 8->72, 15->240) as a square-law gamma for perceptual brightness.
- Undefined: nibble-replicate expansion as above.
- Timing and protocol are identical in both cases.

Test Plan:
1. PIX_NUM=1, FIFO holds 12'hF0A, pulse send_start.
   - Exactly one rd_en.
   - led_dout carries 24 bits 0x00AAFF: 8 zero pulses (20H/42L), then 1010_1010, then 8 one pulses (40H/22L).
   - Then 3000 low cycles, done pulse, busy falls the cycle after done.
2. PIX_NUM=47, 47 entries pre-loaded.
   - 47 rd_en pulses.
   - Every bit period is exactly 62 cycles, including pixel boundaries.
   - Frame length is 47*24*62 + 3000 + 2 cycles, with one done pulse.
3. FIFO with 3 entries, PIX_NUM=47.
   - uflow pulses at the 4th RD.
   - 72 bits are sent, then 3000 low cycles, then done; rd_en count is 3.
4. send_start re-pulsed mid-frame and during LATCH.
   - Ignored: no extra rd_en; frame timing unchanged.
5. rstn asserted during the HIGH phase of bit 10.
   - led_dout=0, busy=0, rd_en=0 immediately; no done.
   - A later send_start starts a clean frame.
6. LED_TX_GAMMA_EN defined, entry 12'h18F.
   - Serialized word is G=72, R=240, B=2, i.e. 0x48F002.
